// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory request/response, redirect input and decode handoff.
interface fetch_controller_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Handshake-driven fetch sequencer: one outstanding imem request, redirect squashing, decode handoff.
// Optional FETCH_PERF_EN adds delivered-instruction and squash event counters.
module fetch_controller #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    fetch_controller_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_squash_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic              squash_q, squash_d;

    logic              redirect;
    logic [XLEN-1:0]   target_aligned;
    logic              req_hs;

    assign redirect       = bus.redirect_valid;
    assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};
    assign req_hs         = req_valid_q & bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    // A redirect hides the held instruction in the same cycle so decode cannot take it.
    assign bus.if_valid       = if_valid_q & ~redirect;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_ADDR;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            squash_q    <= squash_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        squash_d   = squash_q;

        case (state_q)
            ST_IDLE: begin
                if (redirect) pc_d = target_aligned;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) pc_d = target_aligned;
                // A request accepted together with a redirect is already stale.
                if (req_hs) begin
                    squash_d = redirect;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d     = target_aligned;
                    squash_d = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (squash_q || redirect) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        if_instr_d = bus.imem_rsp_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d       = target_aligned;
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (bus.if_ready) begin
                    pc_d       = pc_q + XLEN'(4);
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_valid_d = (state_d == ST_REQ);
    end

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] squash_cnt_q, squash_cnt_d;
    logic            fetch_evt;
    logic            squash_evt;

    // Squash events: response dropped in WAIT, or held instruction discarded in HOLD.
    always_comb begin
        fetch_evt    = (state_q == ST_HOLD) & if_valid_q & ~redirect & bus.if_ready;
        squash_evt   = ((state_q == ST_WAIT) & bus.imem_rsp_valid & (squash_q | redirect))
                     | ((state_q == ST_HOLD) & redirect);
        fetch_cnt_d  = fetch_cnt_q + XLEN'(fetch_evt);
        squash_cnt_d = squash_cnt_q + XLEN'(squash_evt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed cycle table, reset-in-flight sequence, then random traffic
// checked against a stream-level fetch model (expected PC sequence, instruction contents, squash events).
module tb_fetch_controller;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_controller_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    fetch_controller #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_squash_cnt(perf_squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] rsp_addr;
        logic        redir;
        logic [31:0] tgt;
        logic        ifr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;

    // Stream-level model state
    logic [31:0] exp_pc;
    bit          pending, pend_drop, held;
    logic [31:0] pend_addr;
    int          rsp_wait;
    int unsigned delivered, exp_squash;
    bit          prev_stall;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] rsp_addr,
                                input logic redir, input logic [31:0] tgt, input logic ifr,
                                input logic e_rv, input logic [31:0] e_addr,
                                input logic e_ifv, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.rsp_addr = rsp_addr; v.redir = redir; v.tgt = tgt;
        v.ifr = ifr; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc     = RESET_ADDR;
        pending    = 1'b0;
        pend_drop  = 1'b0;
        held       = 1'b0;
        pend_addr  = '0;
        rsp_wait   = 0;
        delivered  = 0;
        exp_squash = 0;
        prev_stall = 1'b0;
        prev_addr  = '0;
    endtask

    task automatic drive(input logic rdy, input logic rsp, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] tgt, input logic ifr);
        bus.imem_req_ready  = rdy;
        bus.imem_rsp_valid  = rsp;
        bus.imem_rsp_data   = rdata;
        bus.redirect_valid  = redir;
        bus.redirect_target = tgt;
        bus.if_ready        = ifr;
    endtask

    // One cycle of the stream model, called after inputs are applied and outputs have settled.
    task automatic observe();
        bit p0, rv, ifv, acc, hs, redir;
        rv    = bus.imem_req_valid;
        ifv   = bus.if_valid;
        redir = bus.redirect_valid;
        if (prev_stall) begin
            chk("req_held_valid", 32'(rv), 32'd1);
            chk("req_held_addr", bus.imem_req_addr, prev_addr);
        end
        if (redir) chk("if_valid_gated", 32'(ifv), 32'd0);
        acc = ifv && bus.if_ready;
        hs  = rv && bus.imem_req_ready;
        p0  = pending;
        if (acc) begin
            chk("deliver_pc", bus.if_pc, exp_pc);
            chk("deliver_instr", bus.if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
            held = 1'b0;
        end
        if (redir) begin
            if (held) exp_squash++;
            held = 1'b0;
            if (pending) pend_drop = 1'b1;
            exp_pc = {bus.redirect_target[31:2], 2'b00};
        end
        if (bus.imem_rsp_valid && p0) begin
            if (pend_drop) exp_squash++;
            else held = 1'b1;
            pending = 1'b0;
        end
        if (hs) begin
            chk("one_outstanding", 32'(pending), 32'd0);
            pending   = 1'b1;
            pend_drop = redir;
            pend_addr = bus.imem_req_addr;
            rsp_wait  = int'($urandom_range(0, 2));
        end
        prev_stall = rv && !bus.imem_req_ready && !redir;
        prev_addr  = bus.imem_req_addr;
    endtask

    task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'(delivered));
        chk({tag, "_perf_squash"}, perf_squash_cnt, 32'(exp_squash));
`else
        if (tag.len() == 0) $display("untagged perf probe");
`endif
    endtask

    initial begin
        vec_t        tbl[$];
        logic        r_rdy, r_rsp, r_redir, r_ifr;
        logic [31:0] r_data, r_tgt;

        // Directed cycle table starting with the first cycle after reset release (IDLE).
        tbl.push_back(mk(0,0,0,          0,0,            0, 0,32'h0,        0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h0,        0,0));
        tbl.push_back(mk(0,1,32'h0,      0,0,            0, 0,32'h0,        0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'h0,        1,32'h0));
        tbl.push_back(mk(0,0,0,          0,0,            0, 1,32'h4,        0,0));
        tbl.push_back(mk(0,0,0,          0,0,            0, 1,32'h4,        0,0));
        tbl.push_back(mk(0,0,0,          0,0,            0, 1,32'h4,        0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h4,        0,0));
        tbl.push_back(mk(0,1,32'h4,      0,0,            0, 0,32'h4,        0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'h4,        1,32'h4));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h8,        0,0));
        tbl.push_back(mk(0,0,0,          1,32'h100,      0, 0,32'h8,        0,0));
        tbl.push_back(mk(0,1,32'h8,      0,0,            0, 0,32'h100,      0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h100,      0,0));
        tbl.push_back(mk(0,1,32'h100,    0,0,            0, 0,32'h100,      0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1,0,0,      0,0,            0, 0,32'h100,      1,32'h100));
        tbl.push_back(mk(1,0,0,          1,32'h203,      1, 0,32'h100,      0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h200,      0,0));
        tbl.push_back(mk(0,1,32'h200,    0,0,            0, 0,32'h200,      0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'h200,      1,32'h200));
        tbl.push_back(mk(0,0,0,          1,32'hFFFF_FFFE,0, 1,32'h204,      0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'hFFFF_FFFC,0,0));
        tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0,          0, 0,32'hFFFF_FFFC,0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h0,        0,0));
        tbl.push_back(mk(0,1,32'h0,      0,0,            0, 0,32'h0,        0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'h0,        1,32'h0));
        tbl.push_back(mk(1,0,0,          1,32'h40,       0, 1,32'h4,        0,0));
        tbl.push_back(mk(0,1,32'h4,      0,0,            0, 0,32'h40,       0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h40,       0,0));
        tbl.push_back(mk(0,1,32'h40,     1,32'h80,       0, 0,32'h40,       0,0));
        tbl.push_back(mk(0,1,32'h1234,   0,0,            0, 1,32'h80,       0,0));
        tbl.push_back(mk(1,0,0,          0,0,            0, 1,32'h80,       0,0));
        tbl.push_back(mk(0,1,32'h80,     0,0,            0, 0,32'h80,       0,0));
        tbl.push_back(mk(0,0,0,          0,0,            1, 0,32'h80,       1,32'h80));
        tbl.push_back(mk(0,0,0,          0,0,            0, 1,32'h84,       0,0));

        model_reset();
        drive(0, 0, '0, 0, '0, 0);
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            if (i == 0) reset = 1'b0;
            drive(tbl[i].rdy, tbl[i].rsp, mem_word(tbl[i].rsp_addr), tbl[i].redir, tbl[i].tgt, tbl[i].ifr);
            #1;
            chk($sformatf("row%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("row%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_if_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_ifv));
            if (tbl[i].e_ifv) begin
                chk($sformatf("row%0d_if_pc", i), bus.if_pc, tbl[i].e_pc);
                chk($sformatf("row%0d_if_instr", i), bus.if_instr, mem_word(tbl[i].e_pc));
            end
            observe();
        end
        chk_perf("table");

        // Reset while a request to 0x84 is outstanding; its response lands during and after reset.
        @(negedge clk);
        drive(1, 0, '0, 0, '0, 0);
        #1 observe();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, mem_word(32'h84), 0, '0, 0);
        #1;
        model_reset();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_ADDR);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk_perf("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_idle_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        drive(0, 0, '0, 0, '0, 0);
        #1;
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", bus.imem_req_addr, RESET_ADDR);
        chk("post_rst_if_valid", 32'(bus.if_valid), 32'd0);
        observe();

        // Random traffic against the stream model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            r_redir = ($urandom % 100) < 6;
            r_tgt   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                            : ($urandom & 32'h0000_FFFF);
            r_rdy   = ($urandom % 3) != 0;
            r_ifr   = ($urandom % 3) != 0;
            if (pending && rsp_wait == 0) begin
                r_rsp  = 1'b1;
                r_data = mem_word(pend_addr);
            end else begin
                r_rsp  = !pending && (($urandom % 10) == 0);
                r_data = $urandom;
                if (pending) rsp_wait--;
            end
            drive(r_rdy, r_rsp, r_data, r_redir, r_tgt, r_ifr);
            #1 observe();
        end
        chk("liveness", 32'(delivered > 200), 32'd1);
        chk_perf("random");

        $display("modelled deliveries %0d, squash events %0d", delivered, exp_squash);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
